lim_counter: RTL and testbench

LIM_COUNTER -- requirements
Module: lim_counter

---
 rtl/lim_counter.sv | 83 ++++++++
 tb/tb_lim_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lim_counter.sv
// rtl/lim_counter.sv - cascaded modulo-L digit counter with load, terminal count and wrap pulse
// Optional down counting (port up) is enabled by defining LIM_COUNTER_DOWN_EN.
module lim_counter #(
  parameter int L      = 10,
  parameter int DIGITS = 4,
  parameter int N      = $clog2(L)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
`ifdef LIM_COUNTER_DOWN_EN
  input  logic                up,
`endif
  input  logic                load,
  input  logic [DIGITS*N-1:0] load_val,
  output logic [DIGITS*N-1:0] count,
  output logic                tc,
  output logic                wrap
);

  localparam logic [N:0] LIM  = (N+1)'(L);
  localparam logic [N:0] LAST = (N+1)'(L - 1);
  localparam logic [N:0] ONE  = (N+1)'(1);

  logic                dir_up;
  logic [DIGITS:0]     carry;
  logic [DIGITS*N-1:0] step_val;
  logic [DIGITS*N-1:0] sat_val;

`ifdef LIM_COUNTER_DOWN_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b1;
`endif

  // carry[i] means every digit below i sits at its terminal value for this direction
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [N-1:0] cur;
    logic [N-1:0] lv;
    logic [N:0]   cur_x;
    logic [N:0]   lv_x;
    logic [N:0]   nxt;
    logic         at_edge;
    logic         unused_msb;

    assign cur     = count[g*N +: N];
    assign lv      = load_val[g*N +: N];
    assign cur_x   = {1'b0, cur};
    assign lv_x    = {1'b0, lv};
    assign at_edge = dir_up ? (cur_x == LAST) : (cur_x == '0);
    assign carry[g+1] = carry[g] & at_edge;

    always_comb begin
      nxt = cur_x;
      if (carry[g]) begin
        if (at_edge)     nxt = dir_up ? '0 : LAST;
        else if (dir_up) nxt = cur_x + ONE;
        else             nxt = cur_x - ONE;
      end
    end

    assign unused_msb          = nxt[N];
    assign step_val[g*N +: N]  = nxt[N-1:0];
    // out-of-range load digits are forced to zero so count never holds a digit >= L
    assign sat_val[g*N +: N]   = (lv_x >= LIM) ? '0 : lv;
  end

  assign tc = en & ~load & carry[DIGITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tc;
      if (load)    count <= sat_val;
      else if (en) count <= step_val;
    end
  end

endmodule

// File: tb/tb_lim_counter.sv
// tb/tb_lim_counter.sv - directed self-checking bench for lim_counter (L=10, DIGITS=2)
module tb_lim_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
`ifdef LIM_COUNTER_DOWN_EN
  logic       up;
`endif
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  lim_counter #(.L(10), .DIGITS(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
`ifdef LIM_COUNTER_DOWN_EN
    .up       (up),
`endif
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
`ifdef LIM_COUNTER_DOWN_EN
    up       = 1'b1;
`endif
    #1;
    check("reset_count", count, 8'h00);
    check("reset_wrap", wrap, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;

    // load 98, step to 99, roll over to 00 with a one-cycle wrap
    load = 1'b1; load_val = 8'h98; tick(); load = 1'b0;
    check("load98_count", count, 8'h98);
    check("load98_tc", tc, 1'b0);
    check("load98_wrap", wrap, 1'b0);
    en = 1'b1; #1;
    check("at98_en_tc", tc, 1'b0);
    tick();
    check("inc99_count", count, 8'h99);
    check("inc99_tc", tc, 1'b1);
    check("inc99_wrap", wrap, 1'b0);
    tick();
    check("roll_count", count, 8'h00);
    check("roll_wrap", wrap, 1'b1);
    check("roll_tc", tc, 1'b0);
    en = 1'b0;
    tick();
    check("wrap_drop", wrap, 1'b0);
    check("hold00_count", count, 8'h00);

    // per-digit saturation
    load = 1'b1; load_val = 8'h3C; tick(); load = 1'b0;
    check("sat_low_digit", count, 8'h30);
    load = 1'b1; load_val = 8'hFF; tick(); load = 1'b0;
    check("sat_both_digits", count, 8'h00);

    // load wins over en
    load = 1'b1; load_val = 8'h05; tick();
    check("load05", count, 8'h05);
    en = 1'b1; load_val = 8'h42; #1;
    check("load_en_tc", tc, 1'b0);
    tick();
    check("load_en_count", count, 8'h42);
    check("load_en_wrap", wrap, 1'b0);

    // loading a terminal value with en high must not assert tc or wrap
    load_val = 8'h99; #1;
    check("load99_en_tc", tc, 1'b0);
    tick();
    check("load99_count", count, 8'h99);
    check("load99_wrap", wrap, 1'b0);
    load = 1'b0; en = 1'b0;

    // carry from digit 0 into digit 1
    load = 1'b1; load_val = 8'h19; tick(); load = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    check("carry_19_20", count, 8'h20);

    // asynchronous reset mid-cycle
    load = 1'b1; load_val = 8'h36; tick(); load = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    check("run37", count, 8'h37);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_count", count, 8'h00);
    check("async_rst_wrap", wrap, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_01", count, 8'h01);
    tick();
    check("post_rst_02", count, 8'h02);
    en = 1'b0;

    // hold for 5 cycles with en low
    load = 1'b1; load_val = 8'h57; tick(); load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold57_count", count, 8'h57);
      check("hold57_tc", tc, 1'b0);
      check("hold57_wrap", wrap, 1'b0);
    end

`ifdef LIM_COUNTER_DOWN_EN
    up = 1'b0;
    load = 1'b1; load_val = 8'h00; tick(); load = 1'b0;
    en = 1'b1; #1;
    check("down00_tc", tc, 1'b1);
    tick();
    check("down_wrap_count", count, 8'h99);
    check("down_wrap_pulse", wrap, 1'b1);
    en = 1'b0;
    load = 1'b1; load_val = 8'h10; tick(); load = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    check("down_borrow_09", count, 8'h09);
    check("down_borrow_wrap", wrap, 1'b0);
    up = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
